// File: rtl/lsu_dbus_master.sv
// Data-memory bus initiator: one load/store in flight, any number of wait states, bus-timeout abort.
// Optional feature macro MISALIGN_TRAP_EN: misaligned word/half accesses abort without a bus cycle.
module lsu_dbus_master #(
    parameter int BIT_WIDTH   = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [BIT_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    output logic                 req_ready,
    output logic                 stall,
    output logic                 resp_valid,
    output logic [BIT_WIDTH-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [BIT_WIDTH-1:0] DAD,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    input  logic                 ACKD_n,
    inout  wire  [BIT_WIDTH-1:0] DDT
);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    localparam bit              TMO_EN   = (TIMEOUT_CYC > 0);
    localparam int              CW       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0]   TMO_LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic {S_IDLE, S_BUS} state_t;

    // Latched access, held stable on the pins for the whole bus cycle.
    typedef struct packed {
        logic [BIT_WIDTH-1:0] addr;
        logic [1:0]           size;
        logic                 write;
        logic                 uns;
        logic [BIT_WIDTH-1:0] wdata;
    } bus_req_t;

    state_t               state, state_nxt;
    bus_req_t             bus_q;
    logic [CW-1:0]        tmo_cnt;
    logic                 in_bus, accept, misalign, bus_go, ack, tmo;
    logic [BIT_WIDTH-1:0] store_fmt, load_ext;

    assign in_bus = (state == S_BUS);
    assign accept = req_valid && (state == S_IDLE);
    assign bus_go = accept && !misalign;
    assign ack    = in_bus && !ACKD_n;
    // An ack on the final counted edge wins over the timeout.
    assign tmo    = TMO_EN && in_bus && ACKD_n && (tmo_cnt == TMO_LAST);

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                      ((req_size == SZ_HALF) && req_addr[0]);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        store_fmt = req_wdata;
        if (req_size == SZ_HALF)
            store_fmt = {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]};
        else if (req_size[1])
            store_fmt = {{(BIT_WIDTH-8){1'b0}}, req_wdata[7:0]};
    end

    // Responder returns sub-word data right-justified on DDT.
    always_comb begin
        load_ext = DDT;
        if (bus_q.size == SZ_HALF)
            load_ext = {{(BIT_WIDTH-16){!bus_q.uns && DDT[15]}}, DDT[15:0]};
        else if (bus_q.size[1])
            load_ext = {{(BIT_WIDTH-8){!bus_q.uns && DDT[7]}}, DDT[7:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus_go)      state_nxt = S_BUS;
            S_BUS:   if (ack || tmo)  state_nxt = S_IDLE;
            default:                  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        MREQ      = (state == S_BUS);
        stall     = (req_valid && !req_ready) || (state == S_BUS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus_q <= '0;
        else if (bus_go)
            bus_q <= '{addr: req_addr, size: req_size, write: req_write,
                       uns: req_unsigned, wdata: store_fmt};
    end

    assign DAD   = bus_q.addr;
    assign SIZE  = bus_q.size;
    assign WRITE = bus_q.write;
    assign DDT   = (MREQ && bus_q.write) ? bus_q.wdata : {BIT_WIDTH{1'bz}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (!in_bus || ack || tmo)
            tmo_cnt <= '0;
        else if (TMO_EN)
            tmo_cnt <= tmo_cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= ack || tmo || (accept && misalign);
            resp_err   <= tmo || (accept && misalign);
            resp_rdata <= (ack && !bus_q.write) ? load_ext : '0;
        end
    end

endmodule

// File: tb/tb_lsu_dbus_master.sv
// Bench for lsu_dbus_master: scripted responder on the data bus, scoreboard of expected responses.
module tb_lsu_dbus_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, stall, resp_valid, resp_err, MREQ, WRITE;
    logic [31:0] resp_rdata, DAD;
    logic [1:0]  SIZE;
    logic        ack_n = 1'b1;
    wire  [31:0] DDT;

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_bad = 0, resp_cnt = 0;
    int cur_waits = 0, bus_cyc = 0;
    logic [31:0] cur_rdata = '0;
    logic ack_en = 1'b1, stray_ack = 1'b0;

    always #5 clk = ~clk;

    lsu_dbus_master #(.BIT_WIDTH(32), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .stall(stall),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE), .ACKD_n(ack_n), .DDT(DDT)
    );

    assign DDT = (MREQ && !WRITE) ? cur_rdata : 'z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Responder: acks after cur_waits wait states; optionally acks stray while idle.
    always @(negedge clk) begin
        if (MREQ) begin
            ack_n = !(ack_en && bus_cyc == cur_waits);
            bus_cyc++;
        end else begin
            bus_cyc = 0;
            ack_n = !stray_ack;
        end
    end

    always @(negedge clk) begin
        if (resp_valid) begin
            resp_cnt++;
            if (sb.size() == 0) chk("spurious_resp", {31'b0, resp_valid}, 32'h0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            end
        end
    end

    task automatic send(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                        input logic [31:0] bus_data, input logic [31:0] exp_rd, input logic exp_err);
        int n;
        req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        chk("req_accept", {31'b0, req_ready}, 32'h1);
        cur_waits = waits; cur_rdata = bus_data;
        sb.push_back('{exp_rd, exp_err});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin @(negedge clk); n++; end
        chk("sb_drain", sb.size(), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        #23 rst = 1'b0;
        @(negedge clk);
        chk("rst_mreq", {31'b0, MREQ}, 32'h0);
        chk("rst_write", {31'b0, WRITE}, 32'h0);
        chk("rst_size", {30'b0, SIZE}, 32'h0);
        chk("rst_dad", DAD, 32'h0);
        chk("rst_resp", {29'b0, resp_valid, resp_err, stall}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        @(posedge clk); #1;

        // Word load, zero wait: MREQ one cycle, response next edge.
        send(1'b0, 2'b00, 1'b0, 32'h0800_0000, 32'h0, 0, 32'h1234_5678, 32'h1234_5678, 1'b0);
        chk("t1_mreq", {31'b0, MREQ}, 32'h1);
        chk("t1_write", {31'b0, WRITE}, 32'h0);
        chk("t1_size", {30'b0, SIZE}, 32'h0);
        chk("t1_dad", DAD, 32'h0800_0000);
        chk("t1_stall", {31'b0, stall}, 32'h1);
        @(posedge clk); #1;
        chk("t1_mreq_drop", {31'b0, MREQ}, 32'h0);
        chk("t1_latency", {31'b0, resp_valid}, 32'h1);
        drain();

        // Sub-word loads, back to back.
        send(1'b0, 2'b10, 1'b0, 32'h0800_0003, 32'h0, 0, 32'h1234_5680, 32'hFFFF_FF80, 1'b0);
        send(1'b0, 2'b11, 1'b1, 32'h0800_0003, 32'h0, 0, 32'h1234_5680, 32'h0000_0080, 1'b0);
        send(1'b0, 2'b01, 1'b0, 32'h0800_0002, 32'h0, 1, 32'h5A5A_8001, 32'hFFFF_8001, 1'b0);
        send(1'b0, 2'b01, 1'b1, 32'h0800_0002, 32'h0, 0, 32'h5A5A_8001, 32'h0000_8001, 1'b0);
        send(1'b0, 2'b01, 1'b0, 32'h0800_0006, 32'h0, 0, 32'hFFFF_7FFF, 32'h0000_7FFF, 1'b0);
        drain();

        // Halfword store: upper bits zeroed on the bus.
        send(1'b1, 2'b01, 1'b0, 32'h0800_0010, 32'h1234_ABCD, 0, 32'h0, 32'h0, 1'b0);
        chk("sh_ddt", DDT, 32'h0000_ABCD);
        drain();

        // Byte store with three wait states.
        base = resp_cnt;
        send(1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'hAAAA_AA41, 3, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sb_mreq", {31'b0, MREQ}, 32'h1);
            chk("sb_ddt", DDT, 32'h0000_0041);
            chk("sb_size", {30'b0, SIZE}, 32'h2);
            chk("sb_stall", {31'b0, stall}, 32'h1);
            chk("sb_no_resp", {31'b0, resp_valid}, 32'h0);
        end
        @(negedge clk);
        chk("sb_mreq_drop", {31'b0, MREQ}, 32'h0);
        chk("sb_resp", {31'b0, resp_valid}, 32'h1);
        drain();
        chk("sb_one_pulse", resp_cnt - base, 32'h1);

        // Timeout: no ack ever, DDT carries junk that must not leak out.
        ack_en = 1'b0;
        send(1'b0, 2'b00, 1'b0, 32'h0800_0010, 32'h0, 0, 32'hCAFE_F00D, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_mreq", {31'b0, MREQ}, 32'h1);
        end
        @(negedge clk);
        chk("to_mreq_drop", {31'b0, MREQ}, 32'h0);
        chk("to_resp_err", {30'b0, resp_valid, resp_err}, 32'h3);
        drain();
        ack_en = 1'b1;
        base = resp_cnt;
        stray_ack = 1'b1;
        repeat (4) @(negedge clk);
        stray_ack = 1'b0;
        chk("to_late_ack", resp_cnt - base, 32'h0);
        chk("to_late_mreq", {31'b0, MREQ}, 32'h0);
        @(posedge clk); #1;

        // Asynchronous reset in the second bus cycle of a store.
        base = resp_cnt;
        send(1'b1, 2'b00, 1'b0, 32'h0800_0040, 32'h1111_2222, 3, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_mreq", {31'b0, MREQ}, 32'h0);
        chk("rst_mid_ready", {31'b0, req_ready}, 32'h1);
        void'(sb.pop_back());
        @(posedge clk); #3;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_noresp", resp_cnt - base, 32'h0);
        @(posedge clk); #1;
        send(1'b0, 2'b00, 1'b0, 32'h0800_0020, 32'h0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0);
        drain();

        // Misaligned word load.
`ifdef MISALIGN_TRAP_EN
        send(1'b0, 2'b00, 1'b0, 32'h0800_0002, 32'h0, 0, 32'h7777_7777, 32'h0, 1'b1);
        chk("mis_no_mreq", {31'b0, MREQ}, 32'h0);
        chk("mis_resp", {30'b0, resp_valid, resp_err}, 32'h3);
`else
        send(1'b0, 2'b00, 1'b0, 32'h0800_0002, 32'h0, 0, 32'h7777_7777, 32'h7777_7777, 1'b0);
        chk("mis_dad", DAD, 32'h0800_0002);
        chk("mis_mreq", {31'b0, MREQ}, 32'h1);
`endif
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
